// File: rtl/barret_pkg.sv
// Shared constants and constant functions for the pipelined Barrett reducer.
// Parameter legality is collected here so every user applies the same rules.
package barret_pkg;

    // Number of bits needed to hold any value in [0, v-1].
    function automatic int barret_clog2(input longint unsigned v);
        int               bits;
        longint unsigned  span;
        bits = 0;
        span = 64'd1;
        while (span < v) begin
            span = span << 1;
            bits++;
        end
        return bits;
    endfunction

    // Barrett constant floor(2^k / q).
    function automatic longint unsigned barret_m(input int q, input int k);
        longint unsigned one;
        longint unsigned qq;
        one = 64'd1;
        qq  = 64'(q);
        return (one << k) / qq;
    endfunction

    function automatic bit barret_params_ok(input int q, input int in_w,
                                            input int k, input int tag_w);
        return (q >= 3) && ((q % 2) == 1) && (in_w >= 1) &&
               (in_w <= k) && (tag_w >= 1);
    endfunction

endpackage

// File: rtl/barret_csub.sv
// One conditional subtraction step: y = (a >= Q) ? a - Q : a.
module barret_csub
    import barret_pkg::*;
#(
    parameter int W = 14,
    parameter int Q = 3461
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] QV = W'(Q);

    assign y = (a >= QV) ? (a - QV) : a;

endmodule

// File: rtl/barret_reduce_pipe.sv
// Three-stage streaming Barrett reducer: dout_r = din_a mod Q, with a tag
// carried alongside each value and a global stall driven by out_ready.
module barret_reduce_pipe
    import barret_pkg::*;
#(
    parameter int Q     = 3461,
    parameter int OUT_W = barret_clog2(64'(Q)),
    parameter int IN_W  = 23,
    parameter int K     = 2 * OUT_W,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din_a,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout_r,
    output logic [TAG_W-1:0] out_tag
);

    localparam longint unsigned M = barret_m(Q, K);
    localparam int M_W    = barret_clog2(M + 64'd1);
    localparam int PROD_W = IN_W + M_W;
    localparam int QH_W   = PROD_W - K;
    localparam int R_W    = OUT_W + 2;
    localparam int SUB_W  = IN_W + R_W;

    localparam logic [M_W-1:0]   M_V = M_W'(M);
    localparam logic [SUB_W-1:0] Q_S = SUB_W'(Q);

    if (!barret_params_ok(Q, IN_W, K, TAG_W)) begin : g_param_err
        $error("barret_reduce_pipe: Q must be odd and >= 3, IN_W <= K, TAG_W >= 1");
    end
    if (QH_W < 1) begin : g_width_err
        $error("barret_reduce_pipe: quotient estimate has no bits");
    end

    logic             adv;
    logic             vld_p0;
    logic             vld_p1;
    logic [IN_W-1:0]  x_p0;
    logic [IN_W-1:0]  x_p1;
    logic [TAG_W-1:0] tag_p0;
    logic [TAG_W-1:0] tag_p1;
    logic [QH_W-1:0]  qh_p1;

    logic [PROD_W-1:0] prod;
    logic [SUB_W-1:0]  diff;
    logic [R_W-1:0]    r0;
    logic [R_W-1:0]    r1;
    logic [R_W-1:0]    r2;

    // Whole pipeline moves together; a blocked output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
        end
    end

    // ---- stage p0: capture input ----
    always_ff @(posedge clk) begin
        if (adv) begin
            x_p0   <= din_a;
            tag_p0 <= in_tag;
        end
    end

    // ---- stage p1: quotient estimate floor(x*M / 2^K), full-width product ----
    assign prod = PROD_W'(x_p0) * PROD_W'(M_V);

    always_ff @(posedge clk) begin
        if (adv) begin
            qh_p1  <= prod[PROD_W-1:K];
            x_p1   <= x_p0;
            tag_p1 <= tag_p0;
        end
    end

    // ---- stage p2: remainder and correction ----
    // The estimate undershoots by at most 2, so the low R_W bits of the
    // difference already hold the exact value in [0, 3Q).
    assign diff = SUB_W'(x_p1) - (SUB_W'(qh_p1) * Q_S);
    assign r0   = diff[R_W-1:0];

    barret_csub #(.W(R_W), .Q(Q)) u_csub0 (
        .a (r0),
        .y (r1)
    );

    barret_csub #(.W(R_W), .Q(Q)) u_csub1 (
        .a (r1),
        .y (r2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r  <= '0;
            out_tag <= '0;
        end else if (adv) begin
            dout_r  <= r2[OUT_W-1:0];
            out_tag <= tag_p1;
        end
    end

endmodule
